// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns the EX/MEM register into one valid/ready
// data-memory transaction at a time and formats load data for writeback.
module mem_access_unit #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        funct3_i,
    input  logic [4:0]        rd_idx_i,
    input  logic              wb_sig_i,
    input  logic              visit_sig_i,
    input  logic              wmem_en_i,
    input  logic [XLEN-1:0]   result_i,
    input  logic [XLEN-1:0]   wmem_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [7:0]        dmem_wstrb_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic [XLEN-1:0]   wb_data_o,
    output logic [4:0]        rd_idx_o,
    output logic              wb_sig_o,
    output logic              hold_o,
    output logic              err_o
);

    typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, ERR} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] addr_q, wdata_q, ldata_q, ld_fmt, sh;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic            wb_q, we_q;
    logic            illegal, misal;
    logic [7:0]      strb;

    // Legality is judged on the incoming instruction so IDLE can branch straight to ERR.
    always_comb begin
        illegal = wmem_en_i ? funct3_i[2] : (funct3_i == 3'b111);
        case (funct3_i[1:0])
            2'd1:    misal = result_i[0];
            2'd2:    misal = |result_i[1:0];
            2'd3:    misal = |result_i[2:0];
            default: misal = 1'b0;
        endcase
    end

    always_comb begin
        sh = dmem_rdata_i >> {addr_q[2:0], 3'b000};
        case (funct3_q)
            3'b000:  ld_fmt = {{56{sh[7]}}, sh[7:0]};
            3'b001:  ld_fmt = {{48{sh[15]}}, sh[15:0]};
            3'b010:  ld_fmt = {{32{sh[31]}}, sh[31:0]};
            3'b100:  ld_fmt = {56'd0, sh[7:0]};
            3'b101:  ld_fmt = {48'd0, sh[15:0]};
            3'b110:  ld_fmt = {32'd0, sh[31:0]};
            default: ld_fmt = sh;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'd0:    strb = 8'h01 << addr_q[2:0];
            2'd1:    strb = 8'h03 << addr_q[2:0];
            2'd2:    strb = 8'h0F << addr_q[2:0];
            default: strb = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            ldata_q  <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && visit_sig_i) begin
                addr_q   <= result_i;
                wdata_q  <= wmem_data_i;
                funct3_q <= funct3_i;
                rd_q     <= rd_idx_i;
                wb_q     <= wb_sig_i;
                we_q     <= wmem_en_i;
            end
            if (state == RESP && dmem_rvalid_i)
                ldata_q <= ld_fmt;
        end
    end

    // Outputs are forced low while reset is asserted, including the IDLE passthrough.
    always_comb begin
        state_n      = state;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        dmem_wstrb_o = '0;
        wb_data_o    = '0;
        rd_idx_o     = '0;
        wb_sig_o     = 1'b0;
        hold_o       = 1'b0;
        err_o        = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    wb_data_o = result_i;
                    rd_idx_o  = rd_idx_i;
                    if (visit_sig_i) begin
                        hold_o  = 1'b1;
                        state_n = (illegal || misal) ? ERR : REQ;
                    end else begin
                        wb_sig_o = wb_sig_i;
                    end
                end
                REQ: begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = we_q;
                    dmem_addr_o  = {addr_q[ADDR_W-1:3], 3'b000};
                    dmem_wdata_o = wdata_q << {addr_q[2:0], 3'b000};
                    dmem_wstrb_o = we_q ? strb : 8'h00;
                    hold_o       = 1'b1;
                    rd_idx_o     = rd_q;
                    if (dmem_gnt_i) state_n = RESP;
                end
                RESP: begin
                    hold_o   = 1'b1;
                    rd_idx_o = rd_q;
                    if (dmem_rvalid_i) state_n = DONE;
                end
                DONE: begin
                    rd_idx_o  = rd_q;
                    wb_data_o = ldata_q;
                    wb_sig_o  = wb_q && !we_q;
                    state_n   = IDLE;
                end
                ERR: begin
                    err_o   = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit; expectations come from a
// byte-level reference model of RV64 load/store rules.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  funct3;
    logic [4:0]  rd_idx;
    logic        wb_sig, visit_sig, wmem_en;
    logic [63:0] result, wmem_data;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [63:0] dmem_rdata, wb_data;
    logic [4:0]  rd_idx_out;
    logic        wb_sig_out, hold, err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst), .funct3_i(funct3), .rd_idx_i(rd_idx), .wb_sig_i(wb_sig),
        .visit_sig_i(visit_sig), .wmem_en_i(wmem_en), .result_i(result), .wmem_data_i(wmem_data),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata), .dmem_wstrb_o(dmem_wstrb), .dmem_gnt_i(dmem_gnt),
        .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata), .wb_data_o(wb_data),
        .rd_idx_o(rd_idx_out), .wb_sig_o(wb_sig_out), .hold_o(hold), .err_o(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic bit ref_bad(input logic we, input logic [2:0] f3, input logic [63:0] a);
        int nbytes = 1 << f3[1:0];
        bit illegal = we ? f3[2] : (f3 == 3'b111);
        return illegal || ((a % nbytes) != 0);
    endfunction

    // Pick the addressed bytes out of the doubleword, then sign- or zero-extend.
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a,
                                             input logic [63:0] d);
        int nbytes = 1 << f3[1:0];
        int off = int'(a[2:0]);
        logic [63:0] v = '0;
        for (int k = 0; k < nbytes; k++) v[8*k +: 8] = d[8*(off+k) +: 8];
        if (!f3[2] && nbytes < 8 && v[8*nbytes-1]) v = v | ~((64'd1 << (8*nbytes)) - 64'd1);
        return v;
    endfunction

    function automatic logic [7:0] ref_strb(input logic [2:0] f3, input logic [63:0] a);
        int nbytes = 1 << f3[1:0];
        int m = ((1 << nbytes) - 1) << int'(a[2:0]);
        return m[7:0];
    endfunction

    // One access from the IDLE cycle to the following IDLE cycle; entry and exit at posedge+1.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] rdat, input int gw,
                       input int rw, input bit abort_resp, output logic [63:0] got);
        logic [4:0] rdv = 5'($urandom);
        logic wbv = 1'($urandom);
        logic [63:0] r;
        got = '0;
        visit_sig = 1'b1; wmem_en = we; funct3 = f3; result = a; wmem_data = wd;
        rd_idx = rdv; wb_sig = wbv; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        chk("idle_hold", hold, 1'b1);
        chk("idle_wb_sig", wb_sig_out, 1'b0);
        chk("idle_req", dmem_req, 1'b0);
        tick();
        if (ref_bad(we, f3, a)) begin
            chk("err_pulse", err, 1'b1);
            chk("err_hold", hold, 1'b0);
            chk("err_req", dmem_req, 1'b0);
            chk("err_wb_sig", wb_sig_out, 1'b0);
            tick();
            visit_sig = 1'b0; wb_sig = 1'b0;
            #1;
            chk("err_one_cycle", err, 1'b0);
            chk("err_after_req", dmem_req, 1'b0);
            return;
        end
        for (int i = 0; i <= gw; i++) begin
            dmem_gnt = (i == gw);
            #1;
            chk("req_valid", dmem_req, 1'b1);
            chk("req_hold", hold, 1'b1);
            chk("req_we", dmem_we, we);
            chk("req_addr", dmem_addr, a & ~64'd7);
            if (we) begin
                chk("req_wstrb", dmem_wstrb, ref_strb(f3, a));
                chk("req_wdata", dmem_wdata, wd << (8 * a[2:0]));
            end
            tick();
        end
        dmem_gnt = 1'b0;
        for (int j = 0; j <= rw; j++) begin
            if (abort_resp) begin
                rst = 1'b0;
                #1;
                chk("rst_hold", hold, 1'b0);
                chk("rst_req", dmem_req, 1'b0);
                chk("rst_wb_sig", wb_sig_out, 1'b0);
                chk("rst_wb_data", wb_data, 64'd0);
                tick();
                rst = 1'b1; visit_sig = 1'b0; wb_sig = 1'b0; r = rnd64(); result = r;
                dmem_rvalid = 1'b1; dmem_rdata = rnd64();
                #1;
                chk("late_rv_wb_sig", wb_sig_out, 1'b0);
                chk("late_rv_hold", hold, 1'b0);
                chk("late_rv_wb_data", wb_data, r);
                tick();
                dmem_rvalid = 1'b0;
                #1;
                chk("late_rv_req", dmem_req, 1'b0);
                chk("late_rv_hold2", hold, 1'b0);
                return;
            end
            dmem_rvalid = (j == rw);
            dmem_rdata = dmem_rvalid ? rdat : rnd64();
            #1;
            chk("resp_req", dmem_req, 1'b0);
            chk("resp_hold", hold, 1'b1);
            tick();
        end
        dmem_rvalid = 1'b0; dmem_rdata = rnd64();
        #1;
        chk("done_hold", hold, 1'b0);
        chk("done_rd", rd_idx_out, rdv);
        chk("done_wb_sig", wb_sig_out, we ? 1'b0 : wbv);
        if (!we) chk("done_wb_data", wb_data, ref_load(f3, a, rdat));
        got = wb_data;
        tick();
        visit_sig = 1'b0; r = rnd64(); result = r; wb_sig = 1'b1; rd_idx = 5'($urandom);
        #1;
        chk("post_done_pass", wb_data, r);
        chk("post_done_hold", hold, 1'b0);
    endtask

    logic [63:0] got, a;
    logic [2:0]  f3;
    logic        we;

    initial begin
        rst = 1'b0; visit_sig = 1'b0; wmem_en = 1'b0; funct3 = 3'd0; rd_idx = 5'd3;
        wb_sig = 1'b1; result = 64'hDEAD_BEEF_0000_1111; wmem_data = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #3;
        chk("reset_wb_data", wb_data, 64'd0);
        chk("reset_wb_sig", wb_sig_out, 1'b0);
        chk("reset_hold", hold, 1'b0);
        chk("reset_req", dmem_req, 1'b0);
        chk("reset_err", err, 1'b0);
        tick();
        rst = 1'b1;

        // ALU passthrough
        visit_sig = 1'b0; result = 64'h1234; rd_idx = 5'd5; wb_sig = 1'b1;
        #1;
        chk("pass_wb_data", wb_data, 64'h1234);
        chk("pass_wb_sig", wb_sig_out, 1'b1);
        chk("pass_rd", rd_idx_out, 5'd5);
        chk("pass_hold", hold, 1'b0);
        tick();

        // Byte loads around the sign boundary
        txn(1'b0, 3'b000, 64'h1000_0003, '0, 64'h0000_0000_8000_0000, 0, 0, 1'b0, got);
        chk("lb_neg_const", got, 64'hFFFF_FFFF_FFFF_FF80);
        txn(1'b0, 3'b100, 64'h1000_0003, '0, 64'h0000_0000_8000_0000, 0, 0, 1'b0, got);
        chk("lbu_const", got, 64'h80);
        txn(1'b0, 3'b000, 64'h1000_0004, '0, 64'h0000_0000_8000_0000, 0, 0, 1'b0, got);
        chk("lb_zero_const", got, 64'h0);
        txn(1'b0, 3'b010, 64'h1000_0004, '0, 64'h8123_4567_0000_0000, 0, 0, 1'b0, got);
        chk("lw_neg_const", got, 64'hFFFF_FFFF_8123_4567);

        // Halfword store into the top lane
        txn(1'b1, 3'b001, 64'h2000_0006, 64'hBEEF, '0, 0, 0, 1'b0, got);

        // Stalls on grant and response: 7-cycle access
        txn(1'b0, 3'b011, 64'h3000_0008, '0, 64'h0123_4567_89AB_CDEF, 2, 1, 1'b0, got);
        chk("ld_stall_const", got, 64'h0123_4567_89AB_CDEF);

        // Misaligned and illegal encodings
        txn(1'b0, 3'b010, 64'h4000_0002, '0, '0, 0, 0, 1'b0, got);
        txn(1'b1, 3'b100, 64'h4000_0000, 64'h1, '0, 0, 0, 1'b0, got);
        txn(1'b0, 3'b111, 64'h4000_0000, '0, '0, 0, 0, 1'b0, got);

        // Reset while waiting for the response
        txn(1'b0, 3'b011, 64'h5000_0000, '0, 64'h55, 0, 0, 1'b1, got);
        txn(1'b0, 3'b001, 64'h5000_0002, '0, 64'h0000_0000_FFFF_0000, 0, 0, 1'b0, got);
        chk("after_rst_lh", got, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            a  = rnd64();
            if ($urandom_range(3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            txn(we, f3, a, rnd64(), rnd64(), $urandom_range(2), $urandom_range(2), 1'b0, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
